// File: rtl/stroke_tracer_if.sv
// Handshake and data bundle for the stroke tracer: start command, control-point
// stream, sample request/response port and stroke status.
interface stroke_tracer_if #(
    parameter int COORD_W = 10,
    parameter int R_W     = 4,
    parameter int CH      = 3,
    parameter int CH_W    = 8,
    parameter int GRAD_W  = 8,
    parameter int LEN_W   = 5
);
    // valid/ready: a transfer happens on a rising clock edge where both are high;
    // the producer holds valid and its data stable until that edge.
    logic                     i_start_valid;
    logic                     o_start_ready;
    logic [COORD_W-1:0]       i_x0;
    logic [COORD_W-1:0]       i_y0;
    logic [R_W-1:0]           i_r;
    logic [CH*CH_W-1:0]       i_stroke_col;
    logic                     i_abort;
    logic                     o_pt_valid;
    logic                     i_pt_ready;
    logic [COORD_W-1:0]       o_pt_x;
    logic [COORD_W-1:0]       o_pt_y;
    logic                     o_smp_valid;
    logic                     i_smp_ready;
    logic [COORD_W-1:0]       o_smp_x;
    logic [COORD_W-1:0]       o_smp_y;
    logic                     i_rsp_valid;
    logic [CH*CH_W-1:0]       i_ref_col;
    logic [CH*CH_W-1:0]       i_canvas_col;
    logic signed [GRAD_W-1:0] i_gx;
    logic signed [GRAD_W-1:0] i_gy;
    logic [GRAD_W-1:0]        i_gm;
    logic                     o_busy;
    logic                     o_done;
    logic [LEN_W-1:0]         o_len;
    logic                     o_aborted;

    modport slave (
        input  i_start_valid, i_x0, i_y0, i_r, i_stroke_col, i_abort, i_pt_ready,
               i_smp_ready, i_rsp_valid, i_ref_col, i_canvas_col, i_gx, i_gy, i_gm,
        output o_start_ready, o_pt_valid, o_pt_x, o_pt_y, o_smp_valid, o_smp_x,
               o_smp_y, o_busy, o_done, o_len, o_aborted
    );

    modport master (
        output i_start_valid, i_x0, i_y0, i_r, i_stroke_col, i_abort, i_pt_ready,
               i_smp_ready, i_rsp_valid, i_ref_col, i_canvas_col, i_gx, i_gy, i_gm,
        input  o_start_ready, o_pt_valid, o_pt_x, o_pt_y, o_smp_valid, o_smp_x,
               o_smp_y, o_busy, o_done, o_len, o_aborted
    );
endinterface

// File: rtl/stroke_tracer.sv
// Brush-stroke tracer: walks perpendicular to the image gradient from a start point,
// emitting fixed-point stroke control points until a termination rule fires.
module stroke_tracer #(
    parameter int COORD_W = 10,
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int CH      = 3,
    parameter int CH_W    = 8,
    parameter int GRAD_W  = 8,
    parameter int R_W     = 4,
    parameter int MIN_LEN = 4,
    parameter int MAX_LEN = 16,
    parameter int F       = 6,
    parameter int FC_SH   = 4,
    parameter int FC      = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    stroke_tracer_if.slave  bus,
    output logic [2:0]      o_dbg_state
);
    localparam int FC_ONE = 1 << FC_SH;
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int P_W    = COORD_W + F + 2;
    localparam int D_W    = F + 3;
    localparam int G1     = GRAD_W + 1;
    localparam int M_W    = GRAD_W + 2;
    localparam int Q_W    = F + 2;
    localparam int CNT_W  = $clog2(Q_W + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_EMIT, S_REQ, S_WAIT, S_DECIDE, S_NORM, S_STEP, S_DONE
    } state_t;

    state_t state, state_n;
    logic   abort_hit;

    logic signed [P_W-1:0]    pos_x, pos_y;
    logic signed [D_W-1:0]    df_x, df_y;
    logic [LEN_W-1:0]         len;
    logic [R_W-1:0]           r_q;
    logic [CH*CH_W-1:0]       col_q, ref_q, can_q;
    logic signed [GRAD_W-1:0] gx_q, gy_q;
    logic [GRAD_W-1:0]        gm_q;
    logic signed [G1-1:0]     dx_q, dy_q;
    logic [M_W-1:0]           mag_q, rem_x, rem_y;
    logic [Q_W-1:0]           nb_x, nb_y, q_x, q_y;
    logic [CNT_W-1:0]         cnt;
    logic                     aborted_q;

    logic                     diff_color;
    logic signed [G1-1:0]     dx_raw, dy_raw, dx_d, dy_d;
    logic [G1-1:0]            ax, ay;
    logic [M_W-1:0]           mag_d;
    logic signed [31:0]       dot;
    logic [M_W:0]             trial_x, trial_y;
    logic                     ge_x, ge_y;
    logic signed [31:0]       u_x, u_y, dfn_x, dfn_y, pos_nx, pos_ny;
    logic                     out_of_img;

    // Colour test: the canvas is already closer to the reference than the stroke would be.
    always_comb begin
        int d_rc;
        int d_rs;
        diff_color = 1'b1;
        d_rc = 0;
        d_rs = 0;
        for (int c = 0; c < CH; c++) begin
            d_rc = int'(ref_q[c*CH_W +: CH_W]) - int'(can_q[c*CH_W +: CH_W]);
            d_rs = int'(ref_q[c*CH_W +: CH_W]) - int'(col_q[c*CH_W +: CH_W]);
            if (!((d_rc < 0 ? -d_rc : d_rc) < (d_rs < 0 ? -d_rs : d_rs)))
                diff_color = 1'b0;
        end
    end

    // Stroke direction is the gradient rotated 90 degrees, flipped to follow the filtered heading.
    always_comb begin
        dx_raw = -G1'(gy_q);
        dy_raw = G1'(gx_q);
        dot    = int'(df_x) * int'(dx_raw) + int'(df_y) * int'(dy_raw);
        dx_d   = (dot < 0) ? -dx_raw : dx_raw;
        dy_d   = (dot < 0) ? -dy_raw : dy_raw;
        ax     = dx_d[G1-1] ? G1'(-dx_d) : G1'(dx_d);
        ay     = dy_d[G1-1] ? G1'(-dy_d) : G1'(dy_d);
        mag_d  = (ax >= ay) ? M_W'(ax) + M_W'(ay >> 1) : M_W'(ay) + M_W'(ax >> 1);
    end

    // One restoring-division step per NORM cycle; the numerator's high part is preloaded
    // into the remainder, so only the low F+2 numerator bits are shifted through.
    always_comb begin
        trial_x = {rem_x, nb_x[Q_W-1]};
        trial_y = {rem_y, nb_y[Q_W-1]};
        ge_x    = trial_x >= {1'b0, mag_q};
        ge_y    = trial_y >= {1'b0, mag_q};
    end

    always_comb begin
        u_x        = dx_q[G1-1] ? -int'(q_x) : int'(q_x);
        u_y        = dy_q[G1-1] ? -int'(q_y) : int'(q_y);
        dfn_x      = (FC * u_x + (FC_ONE - FC) * int'(df_x)) >>> FC_SH;
        dfn_y      = (FC * u_y + (FC_ONE - FC) * int'(df_y)) >>> FC_SH;
        pos_nx     = int'(pos_x) + int'(r_q) * dfn_x;
        pos_ny     = int'(pos_y) + int'(r_q) * dfn_y;
        out_of_img = (pos_nx < 0) || (pos_ny < 0) ||
                     ((pos_nx >>> F) >= IMG_W) || ((pos_ny >>> F) >= IMG_H);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        abort_hit = 1'b0;
        case (state)
            S_IDLE:   if (bus.i_start_valid) state_n = S_EMIT;
            S_EMIT:   if (bus.i_pt_ready)
                          state_n = (len == LEN_W'(MAX_LEN - 1)) ? S_DONE : S_REQ;
            S_REQ:    if (bus.i_smp_ready) state_n = S_WAIT;
            S_WAIT:   if (bus.i_rsp_valid) state_n = S_DECIDE;
            S_DECIDE: if (gm_q == '0 || (len > LEN_W'(MIN_LEN) && diff_color) || mag_d == '0)
                          state_n = S_DONE;
                      else
                          state_n = S_NORM;
            S_NORM:   if (cnt == CNT_W'(Q_W - 1)) state_n = S_STEP;
            S_STEP:   state_n = out_of_img ? S_DONE : S_EMIT;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
        if (state != S_IDLE && state != S_DONE && bus.i_abort) begin
            state_n   = S_DONE;
            abort_hit = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pos_x <= '0;  pos_y <= '0;  df_x <= '0;  df_y <= '0;
            len <= '0;    r_q <= '0;    col_q <= '0; ref_q <= '0; can_q <= '0;
            gx_q <= '0;   gy_q <= '0;   gm_q <= '0;  dx_q <= '0;  dy_q <= '0;
            mag_q <= '0;  rem_x <= '0;  rem_y <= '0; nb_x <= '0;  nb_y <= '0;
            q_x <= '0;    q_y <= '0;    cnt <= '0;   aborted_q <= 1'b0;
        end else begin
            if (abort_hit) aborted_q <= 1'b1;
            case (state)
                S_IDLE: if (bus.i_start_valid) begin
                    pos_x     <= P_W'(int'(bus.i_x0) << F);
                    pos_y     <= P_W'(int'(bus.i_y0) << F);
                    r_q       <= bus.i_r;
                    col_q     <= bus.i_stroke_col;
                    len       <= '0;
                    df_x      <= '0;
                    df_y      <= '0;
                    aborted_q <= 1'b0;
                end
                S_EMIT: if (bus.i_pt_ready && !bus.i_abort) len <= len + 1'b1;
                S_WAIT: if (bus.i_rsp_valid) begin
                    ref_q <= bus.i_ref_col;
                    can_q <= bus.i_canvas_col;
                    gx_q  <= bus.i_gx;
                    gy_q  <= bus.i_gy;
                    gm_q  <= bus.i_gm;
                end
                S_DECIDE: begin
                    dx_q  <= dx_d;
                    dy_q  <= dy_d;
                    mag_q <= mag_d;
                    rem_x <= M_W'(ax >> 2);
                    rem_y <= M_W'(ay >> 2);
                    nb_x  <= {ax[1:0], {F{1'b0}}};
                    nb_y  <= {ay[1:0], {F{1'b0}}};
                    q_x   <= '0;
                    q_y   <= '0;
                    cnt   <= '0;
                end
                S_NORM: begin
                    rem_x <= ge_x ? M_W'(trial_x - {1'b0, mag_q}) : M_W'(trial_x);
                    rem_y <= ge_y ? M_W'(trial_y - {1'b0, mag_q}) : M_W'(trial_y);
                    nb_x  <= nb_x << 1;
                    nb_y  <= nb_y << 1;
                    q_x   <= {q_x[Q_W-2:0], ge_x};
                    q_y   <= {q_y[Q_W-2:0], ge_y};
                    cnt   <= cnt + 1'b1;
                end
                S_STEP: if (!bus.i_abort) begin
                    df_x  <= D_W'(dfn_x);
                    df_y  <= D_W'(dfn_y);
                    pos_x <= P_W'(pos_nx);
                    pos_y <= P_W'(pos_ny);
                end
                default: ;
            endcase
        end
    end

    assign bus.o_start_ready = (state == S_IDLE);
    assign bus.o_busy        = (state != S_IDLE);
    assign bus.o_pt_valid    = (state == S_EMIT);
    assign bus.o_smp_valid   = (state == S_REQ);
    assign bus.o_done        = (state == S_DONE);
    assign bus.o_aborted     = (state == S_DONE) && aborted_q;
    assign bus.o_len         = len;
    assign bus.o_pt_x        = pos_x[F +: COORD_W];
    assign bus.o_pt_y        = pos_y[F +: COORD_W];
    assign bus.o_smp_x       = pos_x[F +: COORD_W];
    assign bus.o_smp_y       = pos_y[F +: COORD_W];
    assign o_dbg_state       = state;
endmodule

// File: tb/tb_stroke_tracer.sv
// Scoreboard bench for stroke_tracer: directed stroke cases plus random strokes
// checked against a plain-arithmetic model of the tracing rules.
module tb_stroke_tracer;
    localparam int ST_IDLE = 0;
    localparam int ST_NORM = 5;

    logic       clk;
    logic       rst;
    logic [2:0] st;

    stroke_tracer_if #(.COORD_W(10), .R_W(4), .CH(3), .CH_W(8), .GRAD_W(8), .LEN_W(5)) bus ();

    stroke_tracer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .o_dbg_state (st)
    );

    typedef struct {
        int          gx;
        int          gy;
        int          gm;
        logic [23:0] refc;
        logic [23:0] canc;
    } smp_t;

    smp_t        smp_tab[16];
    int          stroke_id = 0;
    bit          rand_mode = 1'b1;
    logic        pt_force  = 1'b1;
    logic [19:0] exp_q[$];
    logic [5:0]  end_q[$];
    int          n_checks  = 0;
    int          n_pass    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Consumer back-pressure.
    always @(posedge clk) begin
        #1;
        bus.i_pt_ready  = rand_mode ? ($urandom_range(0, 3) != 0) : pt_force;
        bus.i_smp_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Sample responder: answers each accepted request from the current stroke's table.
    initial begin
        int idx;
        int last_id;
        idx = 0;
        last_id = -1;
        bus.i_rsp_valid  = 1'b0;
        bus.i_ref_col    = '0;
        bus.i_canvas_col = '0;
        bus.i_gx = '0;
        bus.i_gy = '0;
        bus.i_gm = '0;
        forever begin
            @(negedge clk);
            if (rst || !(bus.o_smp_valid && bus.i_smp_ready)) continue;
            if (stroke_id != last_id) begin
                idx = 0;
                last_id = stroke_id;
            end
            @(posedge clk);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            if (idx < 16) begin
                bus.i_gx         = 8'(smp_tab[idx].gx);
                bus.i_gy         = 8'(smp_tab[idx].gy);
                bus.i_gm         = 8'(smp_tab[idx].gm);
                bus.i_ref_col    = smp_tab[idx].refc;
                bus.i_canvas_col = smp_tab[idx].canc;
                idx++;
            end
            bus.i_rsp_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.i_rsp_valid = 1'b0;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a point or ends a stroke.
    initial begin
        logic [19:0] last_pt;
        last_pt = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                end_q.delete();
                continue;
            end
            if (bus.o_pt_valid && bus.i_pt_ready) begin
                chk("pt_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    last_pt = exp_q.pop_front();
                    chk("pt_xy", {bus.o_pt_x, bus.o_pt_y}, last_pt);
                end
            end
            if (bus.o_smp_valid && bus.i_smp_ready)
                chk("smp_xy", {bus.o_smp_x, bus.o_smp_y}, last_pt);
            if (bus.o_done) begin
                chk("end_expected", 32'(end_q.size() != 0), 32'd1);
                if (end_q.size() != 0)
                    chk("len_aborted", {bus.o_len, bus.o_aborted}, end_q.pop_front());
            end
        end
    end

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    // Tracing rules in plain integer arithmetic; positions kept in 1/64 pixel.
    task automatic model_stroke(input int x0, input int y0, input int r, input logic [23:0] sc);
        int px, py, fx, fy, len, k, dx, dy, ax, ay, mag, ux, uy;
        bit closer;
        px = x0 * 64; py = y0 * 64; fx = 0; fy = 0; len = 0; k = 0;
        forever begin
            exp_q.push_back({10'(px / 64), 10'(py / 64)});
            len++;
            if (len == 16) break;
            if (smp_tab[k].gm == 0) break;
            closer = 1'b1;
            for (int c = 0; c < 3; c++) begin
                if (!(iabs(int'(smp_tab[k].refc[c*8 +: 8]) - int'(smp_tab[k].canc[c*8 +: 8])) <
                      iabs(int'(smp_tab[k].refc[c*8 +: 8]) - int'(sc[c*8 +: 8]))))
                    closer = 1'b0;
            end
            if (len > 4 && closer) break;
            dx = -smp_tab[k].gy;
            dy = smp_tab[k].gx;
            k++;
            if (fx * dx + fy * dy < 0) begin
                dx = -dx;
                dy = -dy;
            end
            ax = iabs(dx); ay = iabs(dy);
            mag = (ax > ay) ? ax + ay / 2 : ay + ax / 2;
            if (mag == 0) break;
            ux = (dx * 64) / mag;
            uy = (dy * 64) / mag;
            fx = floor_div(16 * ux, 16);
            fy = floor_div(16 * uy, 16);
            px = px + r * fx;
            py = py + r * fy;
            if (px < 0 || py < 0 || px / 64 >= 640 || py / 64 >= 480) break;
        end
        end_q.push_back({5'(len), 1'b0});
    endtask

    task automatic fill(input int gx, input int gy_even, input int gy_odd, input int gm,
                        input logic [23:0] rc, input logic [23:0] cc);
        for (int i = 0; i < 16; i++) begin
            smp_tab[i].gx   = gx;
            smp_tab[i].gy   = (i % 2 == 0) ? gy_even : gy_odd;
            smp_tab[i].gm   = gm;
            smp_tab[i].refc = rc;
            smp_tab[i].canc = cc;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.o_start_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_reached", 32'(bus.o_start_ready), 32'd1);
    endtask

    task automatic start_stroke(input int x0, input int y0, input int r, input logic [23:0] sc);
        stroke_id++;
        bus.i_x0         = 10'(x0);
        bus.i_y0         = 10'(y0);
        bus.i_r          = 4'(r);
        bus.i_stroke_col = sc;
        bus.i_start_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start_valid = 1'b0;
    endtask

    task automatic push_line(input int n, input int len, input bit ab);
        for (int i = 0; i < n; i++) exp_q.push_back({10'(100 + 4 * i), 10'd50});
        end_q.push_back({5'(len), ab});
    endtask

    initial begin
        int t;
        rst = 1'b1;
        bus.i_start_valid = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_x0 = '0;
        bus.i_y0 = '0;
        bus.i_r = '0;
        bus.i_stroke_col = '0;
        repeat (3) @(negedge clk);
        chk("rst_start_ready", 32'(bus.o_start_ready), 32'd1);
        chk("rst_outputs", {bus.o_busy, bus.o_pt_valid, bus.o_smp_valid, bus.o_done,
                            bus.o_aborted, bus.o_len, bus.o_pt_x}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Straight run to the length limit, then colour stop, then zero gradient.
        fill(0, -8, -8, 8, 24'h808080, 24'h808080);
        push_line(16, 16, 1'b0);
        start_stroke(100, 50, 4, 24'h808080);
        wait_idle();

        fill(0, -8, -8, 8, 24'h808080, 24'h808080);
        push_line(5, 5, 1'b0);
        start_stroke(100, 50, 4, 24'h404040);
        wait_idle();

        fill(0, -8, -8, 0, 24'h808080, 24'h808080);
        push_line(1, 1, 1'b0);
        start_stroke(100, 50, 4, 24'h808080);
        wait_idle();

        // Alternating gradient sign must not reverse the walk.
        fill(0, -8, 8, 8, 24'h808080, 24'h808080);
        push_line(16, 16, 1'b0);
        start_stroke(100, 50, 4, 24'h808080);
        wait_idle();

        // Point near the right edge held under back-pressure; next step leaves the image.
        rand_mode = 1'b0;
        pt_force  = 1'b0;
        fill(0, -8, -8, 8, 24'h808080, 24'h808080);
        exp_q.push_back({10'd637, 10'd50});
        end_q.push_back({5'd1, 1'b0});
        start_stroke(637, 50, 4, 24'h808080);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_pt", {bus.o_pt_valid, bus.o_smp_valid, bus.o_pt_x, bus.o_pt_y},
                {1'b1, 1'b0, 10'd637, 10'd50});
        end
        pt_force = 1'b1;
        wait_idle();
        rand_mode = 1'b1;

        // Abort while normalising.
        fill(0, -8, -8, 8, 24'h808080, 24'h808080);
        push_line(1, 1, 1'b1);
        start_stroke(100, 50, 4, 24'h808080);
        t = 0;
        while (st != 3'(ST_NORM) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("reach_norm", 32'(st), 32'(ST_NORM));
        bus.i_abort = 1'b1;
        @(negedge clk);
        bus.i_abort = 1'b0;
        chk("abort_done", {bus.o_done, bus.o_aborted, bus.o_pt_valid, bus.o_smp_valid}, 32'b1100);
        @(negedge clk);
        chk("abort_ready", 32'(bus.o_start_ready), 32'd1);

        // Random strokes against the model.
        for (int s = 0; s < 30; s++) begin
            int x0, y0, r;
            logic [23:0] sc;
            x0 = $urandom_range(0, 639);
            y0 = $urandom_range(0, 479);
            r  = $urandom_range(1, 15);
            sc = 24'($urandom);
            for (int i = 0; i < 16; i++) begin
                smp_tab[i].gx   = int'($urandom_range(0, 80)) - 40;
                smp_tab[i].gy   = int'($urandom_range(0, 80)) - 40;
                smp_tab[i].gm   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
                smp_tab[i].refc = 24'($urandom);
                smp_tab[i].canc = ($urandom_range(0, 1) == 0) ? smp_tab[i].refc : 24'($urandom);
            end
            model_stroke(x0, y0, r, sc);
            start_stroke(x0, y0, r, sc);
            wait_idle();
        end
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("end_q_drained", 32'(end_q.size()), 32'd0);

        // Asynchronous reset in the middle of a stroke.
        fill(0, -8, -8, 8, 24'h808080, 24'h808080);
        push_line(16, 16, 1'b0);
        start_stroke(100, 50, 4, 24'h808080);
        repeat (25) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {bus.o_busy, bus.o_pt_valid, bus.o_smp_valid, bus.o_done,
                               bus.o_aborted, bus.o_len, bus.o_pt_x}, 32'd0);
        chk("midrst_state", 32'(st), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
